// File: rtl/rx_watchdog_mc.sv
// rx_watchdog_mc: multi-channel receive-path watchdog.
// Raises a bounded reset pulse toward the dot11 core when a decoded SIGNAL
// length is over the limit, or when antenna channels show persistent DC/stuck IQ.
// Optional build macro RX_WATCHDOG_CNT_EN: when defined, rst_count holds a
// saturating count of issued pulses; when undefined, rst_count is tied to 0.
module rx_watchdog_mc #(
    parameter int NUM_CH          = 2,
    parameter int IQ_DATA_WIDTH   = 16,
    parameter int DC_WIN_LOG2     = 5,
    parameter int RST_PULSE_LEN   = 4,
    parameter int HOLDOFF_SAMPLES = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] sample_in,
    input  logic                            sample_in_strobe,
    input  logic [NUM_CH-1:0]               ch_mask,
    input  logic                            dc_any_mode,
    input  logic [15:0]                     signal_len,
    input  logic                            sig_valid,
    input  logic [15:0]                     max_signal_len_th,
    input  logic [7:0]                      dc_running_sum_th,
    output logic                            receiver_rst,
    output logic [1:0]                      rst_cause,
    output logic [15:0]                     rst_count
);

    localparam int ACC_W  = DC_WIN_LOG2 + 2;
    localparam int CMP_W  = ((ACC_W > 8) ? ACC_W : 8) + 1;
    localparam int PCNT_W = $clog2(RST_PULSE_LEN + 1);
    localparam int HCNT_W = $clog2(HOLDOFF_SAMPLES + 1);
    localparam int W2     = 2 * IQ_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // MSB=0 (including zero) maps to +1, MSB=1 maps to -1.
    function automatic logic signed [ACC_W-1:0] sign_of(input logic msb);
        if (msb) return '1;
        return {{(ACC_W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed sum, widened so it compares cleanly with the 8-bit threshold.
    function automatic logic [CMP_W-1:0] mag(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] u;
        u = v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
        return CMP_W'(u);
    endfunction

    state_t                    state_q, state_d;
    logic [PCNT_W-1:0]         pcnt_q, pcnt_d;
    logic [HCNT_W-1:0]         hcnt_q, hcnt_d;
    logic [1:0]                cause_q, cause_d;
    logic                      rst_q, rst_d;
    logic [DC_WIN_LOG2-1:0]    win_q, win_d;
    logic signed [ACC_W-1:0]   acc_i_q [NUM_CH];
    logic signed [ACC_W-1:0]   acc_q_q [NUM_CH];
    logic signed [ACC_W-1:0]   acc_i_d [NUM_CH];
    logic signed [ACC_W-1:0]   acc_q_d [NUM_CH];
    logic signed [ACC_W-1:0]   sum_i   [NUM_CH];
    logic signed [ACC_W-1:0]   sum_q   [NUM_CH];
    logic [NUM_CH-1:0]         trip;
    logic [CMP_W-1:0]          th_ext;
    logic                      mon_active, win_done, dc_hit, dc_trig, len_trig, fire;
    logic                      unused_sample_bits;

    // Only the sign bits of the samples are used.
    assign unused_sample_bits = ^sample_in;

    assign th_ext     = CMP_W'(dc_running_sum_th);
    assign mon_active = (state_q == ST_MONITOR) && enable;
    assign win_done   = mon_active && sample_in_strobe && (&win_q);
    assign dc_hit     = dc_any_mode ? (|(trip & ch_mask))
                                    : ((|ch_mask) && (&(trip | ~ch_mask)));
    assign dc_trig    = win_done && (dc_running_sum_th != 8'd0) && dc_hit;
    assign len_trig   = mon_active && sig_valid && (max_signal_len_th != 16'd0) &&
                        (signal_len > max_signal_len_th);
    assign fire       = (state_q == ST_MONITOR) && (len_trig || dc_trig);

    // Per-channel sign accumulation and end-of-window trip evaluation.
    always_comb begin
        trip  = '0;
        win_d = win_q;
        if (!mon_active)
            win_d = '0;
        else if (sample_in_strobe)
            win_d = win_q + 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_i[c] = acc_i_q[c] + sign_of(sample_in[c*W2 + W2 - 1]);
            sum_q[c] = acc_q_q[c] + sign_of(sample_in[c*W2 + IQ_DATA_WIDTH - 1]);
            trip[c]  = (mag(sum_i[c]) >= th_ext) || (mag(sum_q[c]) >= th_ext);
            acc_i_d[c] = acc_i_q[c];
            acc_q_d[c] = acc_q_q[c];
            if (!mon_active || win_done) begin
                acc_i_d[c] = '0;
                acc_q_d[c] = '0;
            end else if (sample_in_strobe) begin
                acc_i_d[c] = sum_i[c];
                acc_q_d[c] = sum_q[c];
            end
        end
    end

    // Watchdog FSM: monitor, fixed-length pulse, strobe-counted holdoff.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        cause_d = cause_q;
        case (state_q)
            ST_MONITOR: begin
                if (fire) begin
                    state_d = ST_PULSE;
                    pcnt_d  = '0;
                    cause_d = {dc_trig, len_trig};
                end
            end
            ST_PULSE: begin
                if (pcnt_q == PCNT_W'(RST_PULSE_LEN - 1)) begin
                    state_d = ST_HOLDOFF;
                    hcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (sample_in_strobe) begin
                    if (hcnt_q == HCNT_W'(HOLDOFF_SAMPLES - 1))
                        state_d = ST_MONITOR;
                    else
                        hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = ST_MONITOR;
        endcase
        rst_d = (state_d == ST_PULSE);
    end

    // State, counters, accumulators and the registered reset output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_MONITOR;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            cause_q <= '0;
            rst_q   <= 1'b0;
            win_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i_q[c] <= '0;
                acc_q_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            hcnt_q  <= hcnt_d;
            cause_q <= cause_d;
            rst_q   <= rst_d;
            win_q   <= win_d;
            for (int c = 0; c < NUM_CH; c++) begin
                acc_i_q[c] <= acc_i_d[c];
                acc_q_q[c] <= acc_q_d[c];
            end
        end
    end

    assign receiver_rst = rst_q;
    assign rst_cause    = cause_q;

`ifdef RX_WATCHDOG_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] cnt_q, cnt_d;

    // Next pulse count, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (fire)
            cnt_d = sat_inc(cnt_q);
    end

    // Pulse counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign rst_count = cnt_q;
`else
    assign rst_count = '0;
`endif

endmodule
